pipe_fifo: RTL

//  Parametrised successor to the single-stage pipe: synchronous valid/ready FIFO, any DEPTH >= 1.

---
 rtl/pipe_fifo_if.sv | 29 ++
 rtl/pipe_fifo.sv | 62 ++++++
 2 files changed

// File: rtl/pipe_fifo_if.sv
// pipe_fifo_if: valid/ready FIFO bus bundling producer, consumer and status signals
//   master : drives flush, enq_data, enq_valid, deq_ready; observes everything else
//   slave  : the FIFO side, drives enq_ready, deq_*, count and status flags
interface pipe_fifo_if #(
  parameter int DATA_SIZE = 32,
  parameter int CW        = 3
);
  logic                 flush;
  logic [DATA_SIZE-1:0] enq_data;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [DATA_SIZE-1:0] deq_data;
  logic                 deq_valid;
  logic                 deq_ready;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CW-1:0]        max_count;
  modport master (
    output flush, enq_data, enq_valid, deq_ready,
    input  enq_ready, deq_data, deq_valid, count, full, empty, almost_full, almost_empty, max_count
  );
  modport slave (
    input  flush, enq_data, enq_valid, deq_ready,
    output enq_ready, deq_data, deq_valid, count, full, empty, almost_full, almost_empty, max_count
  );
endinterface

// File: rtl/pipe_fifo.sv
// pipe_fifo: parametrised valid/ready FIFO with count, threshold flags, flush, optional fall-through and high-water mark
//   clk, rst        : clock and synchronous active-high reset
//   fifo_io (slave) : flush, enq_* producer side, deq_* consumer side, count/full/empty/almost_*/max_count status
module pipe_fifo #(
  parameter int DATA_SIZE    = 32,
  parameter int DEPTH        = 4,
  parameter int AF_THRESH    = DEPTH,
  parameter int AE_THRESH    = 0,
  parameter int FALL_THROUGH = 0
) (
  input logic        clk,
  input logic        rst,
  pipe_fifo_if.slave fifo_io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (DEPTH < 1 || AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
    $error("pipe_fifo: illegal DEPTH/AF_THRESH/AE_THRESH");
  end
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d, max_q, max_d;
  logic                 empty, full, bypass, wr, rd;
  // an item offered to an empty fall-through FIFO goes straight out; it only lands in storage if the consumer stalls
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == CW'(DEPTH);
    bypass   = FALL_THROUGH != 0 && empty && fifo_io.enq_valid;
    wr       = fifo_io.enq_valid && !full && !(bypass && fifo_io.deq_ready);
    rd       = !empty && fifo_io.deq_ready;
    wr_ptr_d = wr ? (wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = rd ? (rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CW'(wr) - CW'(rd);
    max_d    = count_d > max_q ? count_d : max_q;
  end
  always_ff @(posedge clk) begin
    if (rst || fifo_io.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end
  // storage is never cleared; a write landing during rst/flush is unreachable once the pointers reset
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= fifo_io.enq_data;
  end
  assign fifo_io.enq_ready    = !full;
  assign fifo_io.deq_valid    = !empty || bypass;
  assign fifo_io.deq_data     = bypass ? fifo_io.enq_data : mem_q[rd_ptr_q];
  assign fifo_io.count        = count_q;
  assign fifo_io.full         = full;
  assign fifo_io.empty        = empty;
  assign fifo_io.almost_full  = count_q >= CW'(AF_THRESH);
  assign fifo_io.almost_empty = count_q <= CW'(AE_THRESH);
  assign fifo_io.max_count    = max_q;
endmodule
